// File: rtl/pc_update_unit_pkg.sv
// rtl/pc_update_unit_pkg.sv - cpu_pkg: opcodes, ALU ops, instruction fields, PC FSM encoding
package cpu_pkg;

  localparam int PC_WIDTH = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Opcodes, OPCODE field of the instruction word
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  // ALU operation select
  localparam logic [2:0] ALUOP_FWD = 3'b000;
  localparam logic [2:0] ALUOP_ADD = 3'b001;
  localparam logic [2:0] ALUOP_AND = 3'b010;
  localparam logic [2:0] ALUOP_OR  = 3'b011;

  // Instruction word field positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 24;
  localparam int OFFSET_MSB = 23;
  localparam int OFFSET_LSB = 16;
  localparam int SRC1_MSB   = 15;
  localparam int SRC1_LSB   = 8;
  localparam int SRC2_MSB   = 7;
  localparam int SRC2_LSB   = 0;

  // PC sequencing FSM
  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } pc_state_e;

  // Signed word offset converted to a byte displacement
  function automatic logic [PC_WIDTH-1:0] word_offset_bytes(input logic [7:0] off);
    return {{(PC_WIDTH-10){off[7]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/pc_update_unit_if.sv
// rtl/pc_update_unit_if.sv - flow-control inputs and PC outputs between decoder/ALU and PC unit
interface pc_update_unit_if;

  logic        JUMPENABLE;
  logic        BRANCHENABLE;
  logic        ZERO;
  logic [7:0]  OFFSET;
  logic        BUSYWAIT;
  logic [31:0] PC;
  logic        TAKEN;
  logic [31:0] RETIRE_COUNT;

  // Decoder/ALU/memory side
  modport master (
    output JUMPENABLE, BRANCHENABLE, ZERO, OFFSET, BUSYWAIT,
    input  PC, TAKEN, RETIRE_COUNT
  );

  // PC unit side
  modport slave (
    input  JUMPENABLE, BRANCHENABLE, ZERO, OFFSET, BUSYWAIT,
    output PC, TAKEN, RETIRE_COUNT
  );

endinterface

// File: rtl/pc_update_unit_target_adder.sv
// rtl/pc_update_unit_target_adder.sv - pc_target_adder: sequential and relative-target next PC
module pc_target_adder
  import cpu_pkg::*;
(
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic [7:0]          offset_i,
  output logic [PC_WIDTH-1:0] seq_o,
  output logic [PC_WIDTH-1:0] tgt_o
);

  // Target is relative to the following instruction; both sums wrap silently
  assign seq_o = pc_i + PC_WIDTH'(4);
  assign tgt_o = seq_o + word_offset_bytes(offset_i);

endmodule

// File: rtl/pc_update_unit.sv
// rtl/pc_update_unit.sv - program counter with jump/beq redirect and stall; PC_RETIRE_COUNTER_EN adds a retire counter
module pc_update_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          PC_W     = 32
) (
  input  logic           CLK,
  input  logic           RESET,
  pc_update_unit_if.slave bus
);

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic [PC_W-1:0] seq;
  logic [PC_W-1:0] tgt;
  logic            redirect;
  logic            advance;

  pc_target_adder u_target_adder (
    .pc_i     (pc_q),
    .offset_i (bus.OFFSET),
    .seq_o    (seq),
    .tgt_o    (tgt)
  );

  // Jump wins over branch when both are raised, which folds naturally into the OR
  assign redirect = bus.JUMPENABLE | (bus.BRANCHENABLE & bus.ZERO);

  // Next state and next PC; flow inputs only matter in a cycle that advances
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_HOLD:  state_d = S_RUN;
      S_RUN: begin
        if (bus.BUSYWAIT) state_d = S_STALL;
        else              advance = 1'b1;
      end
      S_STALL: begin
        if (!bus.BUSYWAIT) begin
          advance = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_HOLD;
    endcase
    if (advance) begin
      pc_d    = redirect ? tgt : seq;
      taken_d = redirect;
    end
  end

  // State, PC and redirect pulse registers; reset dominates everything
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_HOLD;
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
    end
  end

  assign bus.PC    = pc_q;
  assign bus.TAKEN = taken_q;

`ifdef PC_RETIRE_COUNTER_EN
  logic [31:0] retire_q;

  // Count every advance, taken or not; wraps at 2^32
  always_ff @(posedge CLK) begin
    if (RESET)        retire_q <= 32'h0;
    else if (advance) retire_q <= retire_q + 32'd1;
  end

  assign bus.RETIRE_COUNT = retire_q;
`else
  assign bus.RETIRE_COUNT = 32'h0;
`endif

endmodule

// File: tb/tb_pc_update_unit.sv
// tb/tb_pc_update_unit.sv - directed self-checking bench for pc_update_unit
module tb_pc_update_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pc_update_unit_if bus0 ();
  pc_update_unit_if bus1 ();

  pc_update_unit #(.RESET_PC(32'h0000_0000)) dut0 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus0)
  );

  pc_update_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic j, input logic b, input logic z, input logic [7:0] off, input logic bw);
    bus0.JUMPENABLE   = j;
    bus0.BRANCHENABLE = b;
    bus0.ZERO         = z;
    bus0.OFFSET       = off;
    bus0.BUSYWAIT     = bw;
  endtask

  task automatic expect_pc(input string tag, input logic [31:0] pc, input logic taken);
    check_eq({tag, "_pc"}, bus0.PC, pc);
    check_eq({tag, "_taken"}, {31'h0, bus0.TAKEN}, {31'h0, taken});
  endtask

  logic [31:0] exp_retire;

  initial begin
    checks   = 0;
    failures = 0;
`ifdef PC_RETIRE_COUNTER_EN
    exp_retire = 32'd5;
`else
    exp_retire = 32'd0;
`endif
    bus1.JUMPENABLE   = 1'b0;
    bus1.BRANCHENABLE = 1'b0;
    bus1.ZERO         = 1'b0;
    bus1.OFFSET       = 8'h00;
    bus1.BUSYWAIT     = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Reset sequencing
    rst = 1'b1;
    step();
    step();
    expect_pc("rst", 32'h0, 1'b0);
    check_eq("rst_retire", bus0.RETIRE_COUNT, 32'h0);
    rst = 1'b0;
    step();
    expect_pc("hold", 32'h0, 1'b0);
    check_eq("wrap_hold_pc", bus1.PC, 32'hFFFF_FFFC);
    step();
    expect_pc("seq4", 32'h4, 1'b0);
    check_eq("wrap_pc", bus1.PC, 32'h0);
    check_eq("wrap_taken", {31'h0, bus1.TAKEN}, 32'h0);
    step();
    expect_pc("seq8", 32'h8, 1'b0);
    step();
    expect_pc("seq12", 32'hC, 1'b0);
    step();
    expect_pc("seq16", 32'h10, 1'b0);

    // Jump forward
    drive(1'b1, 1'b0, 1'b0, 8'h02, 1'b0);
    step();
    expect_pc("jump", 32'h1C, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    expect_pc("after_jump", 32'h20, 1'b0);

    // Branch not taken, back to 0x20, branch taken
    drive(1'b0, 1'b1, 1'b0, 8'hFC, 1'b0);
    step();
    expect_pc("beq_nt", 32'h24, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'hFE, 1'b0);
    step();
    expect_pc("jump_back", 32'h20, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 8'hFC, 1'b0);
    step();
    expect_pc("beq_t", 32'h14, 1'b1);

    // Reach 0x30, then stall with a pending jump
    drive(1'b1, 1'b0, 1'b0, 8'h06, 1'b0);
    step();
    expect_pc("jump_30", 32'h30, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 8'h01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_pc($sformatf("stall%0d", i), 32'h30, 1'b0);
    end
    bus0.BUSYWAIT = 1'b0;
    step();
    expect_pc("stall_release", 32'h38, 1'b1);

    // Offset boundaries and illegal jump+branch
    drive(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
    step();
    expect_pc("self_loop", 32'h38, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 8'h80, 1'b0);
    step();
    expect_pc("off_min", 32'hFFFF_FE3C, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 8'h01, 1'b0);
    step();
    expect_pc("illegal", 32'hFFFF_FE44, 1'b1);

    // Retire count, then reset in the middle of a stall
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    expect_pc("rst2_hold", 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    expect_pc("five_adv", 32'h14, 1'b0);
    check_eq("retire5", bus0.RETIRE_COUNT, exp_retire);
    drive(1'b1, 1'b1, 1'b1, 8'h10, 1'b1);
    step();
    step();
    expect_pc("stall_pre_rst", 32'h14, 1'b0);
    check_eq("retire_stall", bus0.RETIRE_COUNT, exp_retire);
    rst = 1'b1;
    step();
    expect_pc("rst_in_stall", 32'h0, 1'b0);
    check_eq("retire_clr", bus0.RETIRE_COUNT, 32'h0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    expect_pc("rst3_hold", 32'h0, 1'b0);
    step();
    expect_pc("rst3_seq", 32'h4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
